// File: rtl/z3_master_cycle_pkg.sv
// Shared types and helpers for the Zorro III bus-master cycle sequencer.
// Holds the sequencer state encodings, the NCR SIZ codes and the
// size/alignment decode used to validate requests and drive DS_n.
package z3_master_cycle_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    Z3M_IDLE    = 3'd0,
    Z3M_ADDR    = 3'd1,
    Z3M_DATA    = 3'd2,
    Z3M_TERM    = 3'd3,
    Z3M_ERR     = 3'd4,
    Z3M_RECOVER = 3'd5
  } z3m_state_e;

  // NCR 53C710 SIZ encodings
  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  // A request is legal when the transfer fits its natural alignment.
  // Line transfers are run as a single long.
  function automatic logic z3m_req_legal(input logic [1:0] siz, input logic [1:0] a);
    logic legal;
    case (siz)
      SIZ_BYTE: legal = 1'b1;
      SIZ_WORD: legal = ~a[0];
      default:  legal = (a == 2'b00);
    endcase
    return legal;
  endfunction

  // Active-low lane strobes; DS_n[3] is D31:24, the lowest byte address.
  function automatic logic [3:0] z3m_ds_decode(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] ds;
    ds = 4'b1111;
    case (siz)
      SIZ_BYTE: ds[2'd3 - a] = 1'b0;
      SIZ_WORD: ds = a[1] ? 4'b1100 : 4'b0011;
      default:  ds = 4'b0000;
    endcase
    return ds;
  endfunction

endpackage

// File: rtl/z3m_sync.sv
// Two-flop synchronizer for an asynchronous active-low Zorro input.
// Both stages reset to 1 so the synchronized strobe reads negated out of reset.
module z3m_sync (
  input  logic CLK,
  input  logic RESET_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Metastability stage followed by the settled output stage
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle sequencer.
// Turns an NCR 53C710 local-bus master request into a Zorro III cycle
// (FCS_n, DS_n, DOE), waits for DTACK_n/BERR_n and terminates the NCR cycle
// with SCSI_STERM_n or SCSI_BERR_n. All outputs are registered.
// Optional build macro: Z3M_TIMEOUT_EN adds a DTACK wait limit of
// TIMEOUT_CYCLES CLK cycles in DATA, after which the cycle is errored.
module z3_master_cycle
  import z3_master_cycle_pkg::*;
#(
  parameter int unsigned ADDR_SETUP     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       BMASTER,
  input  logic       SCSI_AS_n,
  input  logic       READ,
  input  logic [1:0] SIZ,
  input  logic [1:0] A,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  output logic       FCS_n,
  output logic [3:0] DS_n,
  output logic       DOE,
  output logic       DLATCH,
  output logic       SCSI_STERM_n,
  output logic       SCSI_BERR_n,
  output logic       BUSY
);

  if (ADDR_SETUP < 1 || ADDR_SETUP > 3 || TIMEOUT_CYCLES < 1) begin : gen_param_check
    $error("z3_master_cycle: ADDR_SETUP must be 1..3 and TIMEOUT_CYCLES nonzero");
  end

  // Setup counter value on the last ADDR cycle
  localparam logic [1:0] SetupLast = 2'(ADDR_SETUP - 1);

  z3m_state_e state_q, state_d;
  logic [1:0] setup_cnt_q, setup_cnt_d;
  logic       read_q, read_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] a_q, a_d;

  logic       fcs_n_q, fcs_n_d;
  logic [3:0] ds_n_q, ds_n_d;
  logic       doe_q, doe_d;
  logic       dlatch_q, dlatch_d;
  logic       sterm_n_q, sterm_n_d;
  logic       berr_n_q, berr_n_d;
  logic       busy_q;

  logic       dtack_s;
  logic       berr_s;
  logic       timeout;

  z3m_sync u_sync_dtack (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .async_i (DTACK_n),
    .sync_o  (dtack_s)
  );

  z3m_sync u_sync_berr (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .async_i (BERR_n),
    .sync_o  (berr_s)
  );

`ifdef Z3M_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Timeout fires on the TIMEOUT_CYCLES-th cycle spent in DATA
  assign timeout = (state_q == Z3M_DATA) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  // Count DATA cycles; held at zero everywhere else so entry starts clean
  always_comb begin
    to_cnt_d = '0;
    if (state_q == Z3M_DATA) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // DTACK wait counter register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    read_d      = read_q;
    siz_d       = siz_q;
    a_d         = a_q;
    fcs_n_d     = fcs_n_q;
    ds_n_d      = ds_n_q;
    doe_d       = doe_q;
    dlatch_d    = 1'b0;
    sterm_n_d   = 1'b1;
    berr_n_d    = 1'b1;

    case (state_q)
      Z3M_IDLE: begin
        if (BMASTER && !SCSI_AS_n) begin
          read_d = READ;
          siz_d  = SIZ;
          a_d    = A;
          if (z3m_req_legal(SIZ, A)) begin
            state_d     = Z3M_ADDR;
            setup_cnt_d = '0;
            fcs_n_d     = 1'b0;
            doe_d       = ~READ;
          end else begin
            // Misaligned: fault the NCR without touching the Zorro bus
            state_d  = Z3M_ERR;
            berr_n_d = 1'b0;
          end
        end
      end

      Z3M_ADDR: begin
        if (!BMASTER) begin
          state_d  = Z3M_ERR;
          fcs_n_d  = 1'b1;
          ds_n_d   = 4'b1111;
          doe_d    = 1'b0;
          berr_n_d = 1'b0;
        end else if (setup_cnt_q == SetupLast) begin
          state_d = Z3M_DATA;
          ds_n_d  = z3m_ds_decode(siz_q, a_q);
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end

      Z3M_DATA: begin
        // Bus loss and BERR take priority over a coincident DTACK
        if (!BMASTER || !berr_s || timeout) begin
          state_d  = Z3M_ERR;
          fcs_n_d  = 1'b1;
          ds_n_d   = 4'b1111;
          doe_d    = 1'b0;
          berr_n_d = 1'b0;
        end else if (!dtack_s) begin
          state_d   = Z3M_TERM;
          fcs_n_d   = 1'b1;
          ds_n_d    = 4'b1111;
          doe_d     = 1'b0;
          sterm_n_d = 1'b0;
          dlatch_d  = read_q;
        end
      end

      Z3M_TERM: begin
        state_d = Z3M_RECOVER;
      end

      Z3M_ERR: begin
        state_d = Z3M_RECOVER;
        fcs_n_d = 1'b1;
        ds_n_d  = 4'b1111;
        doe_d   = 1'b0;
      end

      Z3M_RECOVER: begin
        // Slave and NCR must both release before another cycle may begin
        if (dtack_s && berr_s && SCSI_AS_n) begin
          state_d = Z3M_IDLE;
        end
      end

      default: begin
        state_d = Z3M_IDLE;
        fcs_n_d = 1'b1;
        ds_n_d  = 4'b1111;
        doe_d   = 1'b0;
      end
    endcase
  end

  // State, request capture and registered outputs
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= Z3M_IDLE;
      setup_cnt_q <= '0;
      read_q      <= 1'b0;
      siz_q       <= SIZ_LONG;
      a_q         <= 2'b00;
      fcs_n_q     <= 1'b1;
      ds_n_q      <= 4'b1111;
      doe_q       <= 1'b0;
      dlatch_q    <= 1'b0;
      sterm_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      read_q      <= read_d;
      siz_q       <= siz_d;
      a_q         <= a_d;
      fcs_n_q     <= fcs_n_d;
      ds_n_q      <= ds_n_d;
      doe_q       <= doe_d;
      dlatch_q    <= dlatch_d;
      sterm_n_q   <= sterm_n_d;
      berr_n_q    <= berr_n_d;
      busy_q      <= (state_d != Z3M_IDLE);
    end
  end

  assign FCS_n        = fcs_n_q;
  assign DS_n         = ds_n_q;
  assign DOE          = doe_q;
  assign DLATCH       = dlatch_q;
  assign SCSI_STERM_n = sterm_n_q;
  assign SCSI_BERR_n  = berr_n_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_z3_master_cycle.sv
// Directed bench for z3_master_cycle. Inputs change and outputs are sampled
// 1 ns after the rising CLK edge; pulse counters sample on the falling edge.
module tb_z3_master_cycle;

  localparam int unsigned TbTimeout = 8;

  logic       CLK;
  logic       RESET_n;
  logic       BMASTER;
  logic       SCSI_AS_n;
  logic       READ;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       DTACK_n;
  logic       BERR_n;
  logic       FCS_n;
  logic [3:0] DS_n;
  logic       DOE;
  logic       DLATCH;
  logic       SCSI_STERM_n;
  logic       SCSI_BERR_n;
  logic       BUSY;

  int checks = 0;
  int passed = 0;

  int sterm_total  = 0;
  int berr_total   = 0;
  int dlatch_total = 0;
  int fcs_total    = 0;

  z3_master_cycle #(
    .ADDR_SETUP     (1),
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .CLK          (CLK),
    .RESET_n      (RESET_n),
    .BMASTER      (BMASTER),
    .SCSI_AS_n    (SCSI_AS_n),
    .READ         (READ),
    .SIZ          (SIZ),
    .A            (A),
    .DTACK_n      (DTACK_n),
    .BERR_n       (BERR_n),
    .FCS_n        (FCS_n),
    .DS_n         (DS_n),
    .DOE          (DOE),
    .DLATCH       (DLATCH),
    .SCSI_STERM_n (SCSI_STERM_n),
    .SCSI_BERR_n  (SCSI_BERR_n),
    .BUSY         (BUSY)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!SCSI_STERM_n) sterm_total++;
    if (!SCSI_BERR_n)  berr_total++;
    if (DLATCH)        dlatch_total++;
    if (!FCS_n)        fcs_total++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12; i++) begin
      if (!BUSY) break;
      tick();
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; BMASTER = 1'b1; SCSI_AS_n = 1'b1; READ = 1'b0;
    SIZ = 2'b00; A = 2'b00; DTACK_n = 1'b1; BERR_n = 1'b1;
    tick(); tick();
    checks++; if (FCS_n !== 1'b1) $display("FAIL rst_fcs: got %b want 1", FCS_n); else passed++;
    checks++; if (DS_n !== 4'b1111) $display("FAIL rst_ds: got %b want 1111", DS_n); else passed++;
    checks++; if (DOE !== 1'b0) $display("FAIL rst_doe: got %b want 0", DOE); else passed++;
    checks++; if (DLATCH !== 1'b0) $display("FAIL rst_dlatch: got %b want 0", DLATCH); else passed++;
    checks++; if (SCSI_STERM_n !== 1'b1) $display("FAIL rst_sterm: got %b want 1", SCSI_STERM_n);
    else passed++;
    checks++; if (SCSI_BERR_n !== 1'b1) $display("FAIL rst_berr: got %b want 1", SCSI_BERR_n);
    else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else passed++;
    RESET_n = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0) $display("FAIL rst_idle: got %b want 0", BUSY); else passed++;
  endtask

  task automatic test_no_bmaster();
    BMASTER = 1'b0; SCSI_AS_n = 1'b0; SIZ = 2'b00; A = 2'b00;
    tick(); tick(); tick();
    checks++; if (BUSY !== 1'b0) $display("FAIL nobm_busy: got %b want 0", BUSY); else passed++;
    checks++; if (FCS_n !== 1'b1) $display("FAIL nobm_fcs: got %b want 1", FCS_n); else passed++;
    SCSI_AS_n = 1'b1; BMASTER = 1'b1;
    tick();
  endtask

  task automatic test_long_write();
    int s0 = sterm_total;
    int d0 = dlatch_total;
    SIZ = 2'b00; A = 2'b00; READ = 1'b0; SCSI_AS_n = 1'b0;
    tick();
    checks++; if (FCS_n !== 1'b0) $display("FAIL lw_fcs: got %b want 0", FCS_n); else passed++;
    checks++; if (DS_n !== 4'b1111) $display("FAIL lw_ds_early: got %b want 1111", DS_n);
    else passed++;
    checks++; if (BUSY !== 1'b1) $display("FAIL lw_busy: got %b want 1", BUSY); else passed++;
    tick();
    checks++; if (DS_n !== 4'b0000) $display("FAIL lw_ds: got %b want 0000", DS_n); else passed++;
    checks++; if (DOE !== 1'b1) $display("FAIL lw_doe: got %b want 1", DOE); else passed++;
    tick(); tick(); tick();
    DTACK_n = 1'b0;
    tick(); tick();
    checks++; if (SCSI_STERM_n !== 1'b1) $display("FAIL lw_sterm_early: got %b want 1",
                                                   SCSI_STERM_n); else passed++;
    checks++; if (FCS_n !== 1'b0) $display("FAIL lw_fcs_held: got %b want 0", FCS_n); else passed++;
    tick();
    checks++; if (SCSI_STERM_n !== 1'b0) $display("FAIL lw_sterm: got %b want 0", SCSI_STERM_n);
    else passed++;
    checks++; if ({FCS_n, DS_n, DOE} !== 6'b111110) $display("FAIL lw_negate: got %b want 111110",
                                                          {FCS_n, DS_n, DOE}); else passed++;
    tick();
    checks++; if (SCSI_STERM_n !== 1'b1) $display("FAIL lw_sterm_end: got %b want 1",
                                                   SCSI_STERM_n); else passed++;
    // Slave released but NCR still holds AS: must stay in recovery
    DTACK_n = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if ({BUSY, FCS_n} !== 2'b11) $display("FAIL lw_recover_hold: got %b want 11",
                                                  {BUSY, FCS_n}); else passed++;
    SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL lw_idle: got %b want 0", BUSY); else passed++;
    checks++; if (sterm_total - s0 !== 1) $display("FAIL lw_sterm_count: got %0d want 1",
                                                   sterm_total - s0); else passed++;
    checks++; if (dlatch_total - d0 !== 0) $display("FAIL lw_dlatch_count: got %0d want 0",
                                                    dlatch_total - d0); else passed++;
  endtask

  task automatic test_byte_read();
    int s0 = sterm_total;
    int d0 = dlatch_total;
    SIZ = 2'b01; A = 2'b10; READ = 1'b1; SCSI_AS_n = 1'b0;
    tick();
    checks++; if ({FCS_n, DOE} !== 2'b00) $display("FAIL br_fcs_doe: got %b want 00",
                                                  {FCS_n, DOE}); else passed++;
    tick();
    checks++; if (DS_n !== 4'b1101) $display("FAIL br_ds: got %b want 1101", DS_n); else passed++;
    DTACK_n = 1'b0;
    tick(); tick();
    checks++; if (DLATCH !== 1'b0) $display("FAIL br_dlatch_early: got %b want 0", DLATCH);
    else passed++;
    tick();
    checks++; if ({DLATCH, FCS_n, DS_n, SCSI_STERM_n} !== 7'b1111110)
      $display("FAIL br_term: got %b want 1111110", {DLATCH, FCS_n, DS_n, SCSI_STERM_n});
    else passed++;
    tick();
    checks++; if (DLATCH !== 1'b0) $display("FAIL br_dlatch_end: got %b want 0", DLATCH);
    else passed++;
    DTACK_n = 1'b1; SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL br_idle: got %b want 0", BUSY); else passed++;
    checks++; if (dlatch_total - d0 !== 1) $display("FAIL br_dlatch_count: got %0d want 1",
                                                    dlatch_total - d0); else passed++;
    checks++; if (sterm_total - s0 !== 1) $display("FAIL br_sterm_count: got %0d want 1",
                                                   sterm_total - s0); else passed++;
  endtask

  task automatic test_ds_decode();
    logic [1:0] siz_tab [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [1:0] a_tab   [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
    logic [3:0] ds_tab  [4] = '{4'b0111, 4'b0011, 4'b1100, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      SIZ = siz_tab[i]; A = a_tab[i]; READ = 1'b1; SCSI_AS_n = 1'b0;
      tick(); tick();
      checks++; if (DS_n !== ds_tab[i]) $display("FAIL ds_decode[%0d]: got %b want %b", i, DS_n,
                                                 ds_tab[i]); else passed++;
      DTACK_n = 1'b0;
      tick(); tick(); tick();
      checks++; if (SCSI_STERM_n !== 1'b0) $display("FAIL ds_sterm[%0d]: got %b want 0", i,
                                                     SCSI_STERM_n); else passed++;
      DTACK_n = 1'b1; SCSI_AS_n = 1'b1;
      wait_idle();
      checks++; if (BUSY !== 1'b0) $display("FAIL ds_idle[%0d]: got %b want 0", i, BUSY);
      else passed++;
    end
  endtask

  task automatic test_misaligned();
    int f0 = fcs_total;
    int b0 = berr_total;
    SIZ = 2'b10; A = 2'b01; READ = 1'b1; SCSI_AS_n = 1'b0;
    tick();
    checks++; if ({SCSI_BERR_n, FCS_n, BUSY} !== 3'b011) $display("FAIL mis_word: got %b want 011",
                                                           {SCSI_BERR_n, FCS_n, BUSY}); else passed++;
    tick();
    checks++; if (SCSI_BERR_n !== 1'b1) $display("FAIL mis_berr_end: got %b want 1", SCSI_BERR_n);
    else passed++;
    SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL mis_idle: got %b want 0", BUSY); else passed++;
    SIZ = 2'b00; A = 2'b10; SCSI_AS_n = 1'b0;
    tick();
    checks++; if ({SCSI_BERR_n, FCS_n} !== 2'b01) $display("FAIL mis_long: got %b want 01",
                                                    {SCSI_BERR_n, FCS_n}); else passed++;
    SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (fcs_total - f0 !== 0) $display("FAIL mis_fcs_count: got %0d want 0",
                                                 fcs_total - f0); else passed++;
    checks++; if (berr_total - b0 !== 2) $display("FAIL mis_berr_count: got %0d want 2",
                                                  berr_total - b0); else passed++;
  endtask

  task automatic test_dtack_berr_same();
    int s0 = sterm_total;
    int b0 = berr_total;
    SIZ = 2'b00; A = 2'b00; READ = 1'b1; SCSI_AS_n = 1'b0;
    tick(); tick();
    DTACK_n = 1'b0; BERR_n = 1'b0;
    tick(); tick(); tick();
    checks++; if ({SCSI_BERR_n, SCSI_STERM_n, FCS_n} !== 3'b011)
      $display("FAIL both_resp: got %b want 011", {SCSI_BERR_n, SCSI_STERM_n, FCS_n});
    else passed++;
    tick();
    checks++; if (SCSI_BERR_n !== 1'b1) $display("FAIL both_berr_end: got %b want 1", SCSI_BERR_n);
    else passed++;
    DTACK_n = 1'b1; BERR_n = 1'b1; SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL both_idle: got %b want 0", BUSY); else passed++;
    checks++; if (sterm_total - s0 !== 0) $display("FAIL both_sterm_count: got %0d want 0",
                                                   sterm_total - s0); else passed++;
    checks++; if (berr_total - b0 !== 1) $display("FAIL both_berr_count: got %0d want 1",
                                                  berr_total - b0); else passed++;
  endtask

  task automatic test_bmaster_drop();
    int s0 = sterm_total;
    SIZ = 2'b00; A = 2'b00; READ = 1'b0; SCSI_AS_n = 1'b0;
    tick(); tick();
    checks++; if (DS_n !== 4'b0000) $display("FAIL bm_ds: got %b want 0000", DS_n); else passed++;
    BMASTER = 1'b0;
    tick();
    checks++; if ({FCS_n, DS_n, DOE, SCSI_BERR_n} !== 7'b1111100)
      $display("FAIL bm_drop: got %b want 1111100", {FCS_n, DS_n, DOE, SCSI_BERR_n});
    else passed++;
    tick();
    checks++; if (SCSI_BERR_n !== 1'b1) $display("FAIL bm_berr_end: got %b want 1", SCSI_BERR_n);
    else passed++;
    BMASTER = 1'b1; SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL bm_idle: got %b want 0", BUSY); else passed++;
    checks++; if (sterm_total - s0 !== 0) $display("FAIL bm_sterm_count: got %0d want 0",
                                                   sterm_total - s0); else passed++;
  endtask

  task automatic test_reset_mid();
    SIZ = 2'b00; A = 2'b00; READ = 1'b0; SCSI_AS_n = 1'b0;
    tick(); tick();
    #5;
    RESET_n = 1'b0;
    #1;
    checks++; if ({FCS_n, DS_n, BUSY} !== 6'b111110) $display("FAIL rm_async: got %b want 111110",
                                                          {FCS_n, DS_n, BUSY}); else passed++;
    SCSI_AS_n = 1'b1;
    tick();
    RESET_n = 1'b1;
    tick();
    SCSI_AS_n = 1'b0;
    tick();
    checks++; if (FCS_n !== 1'b0) $display("FAIL rm_fcs: got %b want 0", FCS_n); else passed++;
    tick();
    DTACK_n = 1'b0;
    tick(); tick(); tick();
    checks++; if (SCSI_STERM_n !== 1'b0) $display("FAIL rm_sterm: got %b want 0", SCSI_STERM_n);
    else passed++;
    DTACK_n = 1'b1; SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL rm_idle: got %b want 0", BUSY); else passed++;
  endtask

`ifdef Z3M_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    SIZ = 2'b00; A = 2'b00; READ = 1'b1; SCSI_AS_n = 1'b0;
    tick(); tick();
    for (int i = 1; i < int'(TbTimeout); i++) begin
      tick();
      if (!SCSI_BERR_n) early++;
    end
    checks++; if (early !== 0) $display("FAIL to_early: got %0d want 0", early); else passed++;
    tick();
    checks++; if ({SCSI_BERR_n, FCS_n} !== 2'b01) $display("FAIL to_berr: got %b want 01",
                                                    {SCSI_BERR_n, FCS_n}); else passed++;
    SCSI_AS_n = 1'b1;
    wait_idle();
    checks++; if (BUSY !== 1'b0) $display("FAIL to_idle: got %b want 0", BUSY); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_no_bmaster();
    test_long_write();
    test_byte_read();
    test_ds_decode();
    test_misaligned();
    test_dtack_berr_same();
    test_bmaster_drop();
    test_reset_mid();
`ifdef Z3M_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/z3_master_cycle.md
Name: z3_master_cycle

Overview:
- Zorro III bus-master cycle sequencer: the initiator counterpart to the board's slave responder.
- Converts an NCR 53C710 local-bus master request (SCSI_AS_n, SIZ, A[1:0], READ) into a Zorro III cycle: FCS_n, DS_n[3:0], DOE, then waits for DTACK_n/BERR_n.
- Terminates the NCR cycle with SCSI_STERM_n (success) or SCSI_BERR_n (error).
- Sits between zorro_master_arbiter (supplies BMASTER) and the Zorro bus/buffer controls, clocked by the 25 MHz board CLK.

Parameters:
ADDR_SETUP, 1, CLK cycles FCS_n is held low before DS_n asserts (1..3)
TIMEOUT_CYCLES, 255, DTACK wait limit in CLK cycles (used only with Z3M_TIMEOUT_EN)

Ports:
CLK  input  1  25 MHz board clock
RESET_n  input  1  asynchronous active-low reset
BMASTER  input  1  board owns Zorro bus (from arbiter)
SCSI_AS_n  input  1  NCR address strobe, local-bus synchronous to CLK
READ  input  1  1 = read from Zorro, 0 = write
SIZ  input  2  NCR size: 00 long, 01 byte, 10 word, 11 line (treated as long)
A  input  2  NCR address bits [1:0]
DTACK_n  input  1  Zorro DTACK, asynchronous
BERR_n  input  1  Zorro BERR, asynchronous
FCS_n  output  1  Zorro full cycle strobe (top tristates when !BMASTER)
DS_n  output  4  Zorro data strobes, DS_n[3] = D31:24
DOE  output  1  data output enable, write cycles only
DLATCH  output  1  one-cycle read-data capture strobe
SCSI_STERM_n  output  1  NCR cycle terminate
SCSI_BERR_n  output  1  NCR bus error
BUSY  output  1  sequencer not in IDLE

Behaviour:
- Reset: FCS_n=1, DS_n=4'b1111, DOE=0, DLATCH=0, SCSI_STERM_n=1, SCSI_BERR_n=1, BUSY=0, state IDLE, counters 0. All outputs registered.
- DTACK_n and BERR_n pass through two-flop synchronizers (reset to 1). Decisions use the synchronized values.
- States: IDLE, ADDR, DATA, TERM, ERR, RECOVER.
- IDLE:
  - On BMASTER=1 and SCSI_AS_n=0, check the size/alignment request.
  - Legal -> ADDR; FCS_n=0 at the same edge.
  - Illegal (word with A[0]=1; long/line with A!=00) -> ERR with no Zorro cycle.
- ADDR: hold ADDR_SETUP cycles, then -> DATA. DS_n is driven from the decode below; DOE=!READ.
- DS decode:
  - Byte: DS_n[3-A]=0.
  - Word, A[1]=0: DS_n=0011. Word, A[1]=1: DS_n=1100.
  - Long/line: 0000.
- DATA: wait for synchronized DTACK_n=0.
  - On DTACK -> TERM. Negate FCS_n, DS_n and DOE at that edge. DLATCH=1 for one cycle if READ.
  - Synchronized BERR_n=0 -> ERR. BERR wins over a simultaneous DTACK.
- TERM: SCSI_STERM_n=0 for exactly one cycle -> RECOVER.
- ERR: SCSI_BERR_n=0 for exactly one cycle; FCS_n/DS_n/DOE negated -> RECOVER.
- RECOVER: wait until synchronized DTACK_n=1, synchronized BERR_n=1 and SCSI_AS_n=1 -> IDLE. No new cycle may start before that.
- BMASTER drops in ADDR or DATA: negate all Zorro strobes at the next edge -> ERR. In IDLE or RECOVER it is ignored.
- Minimum latency: AS sampled -> FCS_n low 1 cycle. With ADDR_SETUP=1, DS_n low at cycle 2. STERM follows DTACK sync by 3 cycles.
- BUSY=1 in every state except IDLE.
- Reset mid-cycle: all outputs return immediately (asynchronously) to their reset values.

Optional Feature:
- Macro: Z3M_TIMEOUT_EN.
- Defined: a TIMEOUT_CYCLES counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering DATA and counts each DATA cycle. When it reaches TIMEOUT_CYCLES without DTACK/BERR -> ERR (strobes negated, SCSI_BERR_n pulse).
- Undefined: no counter; DATA waits indefinitely for DTACK_n/BERR_n or BMASTER loss.

Decomposition:
- State encodings (Z3M_IDLE..Z3M_RECOVER) and SIZ codes (SIZ_LONG/BYTE/WORD/LINE) go in globalparams.vh.
- One sub-module, z3m_sync: 2-flop asynchronous-input synchronizer with reset-to-1. Instantiated for DTACK_n and BERR_n.

Test Plan:
- Long write (SIZ=00, A=00, READ=0), DTACK after 4 cycles -> FCS_n low 1 cycle after AS, DS_n=0000, DOE=1; one STERM pulse; DLATCH stays 0; returns to IDLE after AS high.
- Byte read (SIZ=01, A=10) -> DS_n=1101, DOE=0; DLATCH one-cycle pulse coincident with strobe negation; one STERM pulse.
- Misaligned word (SIZ=10, A=01) -> FCS_n never asserts; SCSI_BERR_n single pulse within 2 cycles.
- DTACK and BERR asserted on the same edge during DATA -> SCSI_BERR_n pulse, SCSI_STERM_n stays 1.
- BMASTER dropped while DS_n asserted -> strobes negated next edge, SCSI_BERR_n pulse, no STERM. With Z3M_TIMEOUT_EN and TIMEOUT_CYCLES=8, no DTACK -> BERR pulse 8 cycles into DATA.
- RESET_n asserted in DATA -> FCS_n=1, DS_n=1111, BUSY=0 immediately; a new request after reset completes normally.
